// File: rtl/fft_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fft_pkg: widths, complex-bin types and streamer states shared by the FFT core,
// its downstream blocks and their benches.                             Rev 1.0
// ----------------------------------------------------------------------------
package fft_pkg;

   localparam int N_BINS = 8;
   localparam int IN_W   = 16;
   localparam int PWR_W  = 32;
   localparam int IDX_W  = 3;

   typedef struct packed {
      logic signed [IN_W-1:0] re;
      logic signed [IN_W-1:0] im;
   } cbin_t;

   typedef cbin_t [N_BINS-1:0] frame_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } strm_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_bin_power.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fft_bin_power: combinational power of one complex bin, re^2 + im^2, unsigned.
//                                                                      Rev 1.0
// ----------------------------------------------------------------------------
module fft_bin_power
   import fft_pkg::*;
(
   input  logic [IN_W-1:0]  re_i,
   input  logic [IN_W-1:0]  im_i,
   output logic [PWR_W-1:0] power_o
);

   logic signed [2*IN_W-1:0] w_sq_re;
   logic signed [2*IN_W-1:0] w_sq_im;

   assign w_sq_re = $signed(re_i) * $signed(re_i);
   assign w_sq_im = $signed(im_i) * $signed(im_i);

   // Each square is at most 2^30, so the unsigned sum peaks at 2^31 and never wraps.
   assign power_o = PWR_W'($unsigned(w_sq_re)) + PWR_W'($unsigned(w_sq_im));

endmodule
`default_nettype wire

// File: rtl/fft_bin_streamer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fft_bin_streamer: captures an 8-bin FFT frame, streams bins with their power
// over valid/ready and reports each frame's peak bin.                  Rev 1.0
// ----------------------------------------------------------------------------
module fft_bin_streamer
   import fft_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [IN_W-1:0]   real_in1,
   input  logic [IN_W-1:0]   real_in2,
   input  logic [IN_W-1:0]   real_in3,
   input  logic [IN_W-1:0]   real_in4,
   input  logic [IN_W-1:0]   real_in5,
   input  logic [IN_W-1:0]   real_in6,
   input  logic [IN_W-1:0]   real_in7,
   input  logic [IN_W-1:0]   real_in8,
   input  logic [IN_W-1:0]   imag_in1,
   input  logic [IN_W-1:0]   imag_in2,
   input  logic [IN_W-1:0]   imag_in3,
   input  logic [IN_W-1:0]   imag_in4,
   input  logic [IN_W-1:0]   imag_in5,
   input  logic [IN_W-1:0]   imag_in6,
   input  logic [IN_W-1:0]   imag_in7,
   input  logic [IN_W-1:0]   imag_in8,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_idx,
   output logic [IN_W-1:0]   out_real,
   output logic [IN_W-1:0]   out_imag,
   output logic [PWR_W-1:0]  out_power,
   output logic              out_last,
   output logic              peak_valid,
   output logic [IDX_W-1:0]  peak_idx,
   output logic [PWR_W-1:0]  peak_power,
   output logic              overflow,
   input  logic              ovf_clr,
   output logic [7:0]        frame_cnt
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS - 1);
   localparam logic [3:0]       CNT_FULL = 4'(N_BINS);

   strm_state_t       state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   frame_t            stream_q, stream_d;
   frame_t            pend_q, pend_d;
   logic              pend_full_q, pend_full_d;

   logic              out_valid_q, out_valid_d;
   logic [IDX_W-1:0]  out_idx_q, out_idx_d;
   logic [IN_W-1:0]   out_real_q, out_real_d;
   logic [IN_W-1:0]   out_imag_q, out_imag_d;
   logic [PWR_W-1:0]  out_power_q, out_power_d;
   logic              out_last_q, out_last_d;

   logic [PWR_W-1:0]  run_pwr_q, run_pwr_d;
   logic [IDX_W-1:0]  run_idx_q, run_idx_d;
   logic              peak_valid_q, peak_valid_d;
   logic [IDX_W-1:0]  peak_idx_q, peak_idx_d;
   logic [PWR_W-1:0]  peak_power_q, peak_power_d;
   logic              overflow_q, overflow_d;
   logic [7:0]        frame_cnt_q, frame_cnt_d;

   frame_t            w_in_frame;
   logic              w_accept;
   logic              w_slot;
   logic              w_done;
   logic              w_load;
   logic [IDX_W-1:0]  w_sel_idx;
   cbin_t             w_sel_bin;
   logic [PWR_W-1:0]  w_sel_pwr;
   logic              w_drop;
   logic [PWR_W-1:0]  w_base_pwr;
   logic [IDX_W-1:0]  w_base_idx;
   logic [PWR_W-1:0]  w_max_pwr;
   logic [IDX_W-1:0]  w_max_idx;

   assign w_in_frame[0] = {real_in1, imag_in1};
   assign w_in_frame[1] = {real_in2, imag_in2};
   assign w_in_frame[2] = {real_in3, imag_in3};
   assign w_in_frame[3] = {real_in4, imag_in4};
   assign w_in_frame[4] = {real_in5, imag_in5};
   assign w_in_frame[5] = {real_in6, imag_in6};
   assign w_in_frame[6] = {real_in7, imag_in7};
   assign w_in_frame[7] = {real_in8, imag_in8};

   assign w_accept = out_valid_q && out_ready;
   assign w_slot   = !out_valid_q || out_ready;
   assign w_done   = (state_q == ST_STREAM) && (cnt_q == CNT_FULL) && w_accept;

   // Bin feeding the output register; on the final accept PEND bin 0 goes straight in.
   always_comb begin
      w_load    = 1'b0;
      w_sel_idx = cnt_q[IDX_W-1:0];
      w_sel_bin = stream_q[cnt_q[IDX_W-1:0]];
      if (state_q == ST_STREAM) begin
         if (w_done) begin
            if (pend_full_q) begin
               w_load    = 1'b1;
               w_sel_idx = '0;
               w_sel_bin = pend_q[0];
            end
         end else if ((cnt_q != CNT_FULL) && w_slot) begin
            w_load = 1'b1;
         end
      end
   end

   fft_bin_power u_power (
      .re_i    (w_sel_bin.re),
      .im_i    (w_sel_bin.im),
      .power_o (w_sel_pwr)
   );

   // Running max restarts from zero at bin 0; strict compare keeps the lower index on ties.
   assign w_base_pwr = (out_idx_q == '0) ? '0 : run_pwr_q;
   assign w_base_idx = (out_idx_q == '0) ? '0 : run_idx_q;
   assign w_max_pwr  = (out_power_q > w_base_pwr) ? out_power_q : w_base_pwr;
   assign w_max_idx  = (out_power_q > w_base_pwr) ? out_idx_q   : w_base_idx;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      stream_d     = stream_q;
      pend_d       = pend_q;
      pend_full_d  = pend_full_q;
      out_valid_d  = out_valid_q;
      out_idx_d    = out_idx_q;
      out_real_d   = out_real_q;
      out_imag_d   = out_imag_q;
      out_power_d  = out_power_q;
      out_last_d   = out_last_q;
      run_pwr_d    = run_pwr_q;
      run_idx_d    = run_idx_q;
      peak_valid_d = 1'b0;
      peak_idx_d   = peak_idx_q;
      peak_power_d = peak_power_q;
      frame_cnt_d  = frame_cnt_q;
      w_drop       = 1'b0;

      if (w_load) begin
         out_valid_d = 1'b1;
         out_idx_d   = w_sel_idx;
         out_real_d  = w_sel_bin.re;
         out_imag_d  = w_sel_bin.im;
         out_power_d = w_sel_pwr;
         out_last_d  = (w_sel_idx == LAST_IDX);
         cnt_d       = w_done ? 4'd1 : cnt_q + 4'd1;
         if (w_done) begin
            stream_d = pend_q;
         end
      end else if (w_slot) begin
         out_valid_d = 1'b0;
      end

      if (w_done) begin
         pend_full_d = 1'b0;
         if (!pend_full_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      end

      // STREAM frees up this edge if its last beat leaves with nothing pending.
      if (in_valid) begin
         if ((state_q == ST_IDLE) || (w_done && !pend_full_q)) begin
            stream_d = w_in_frame;
            state_d  = ST_STREAM;
            cnt_d    = '0;
         end else if (!pend_full_q || w_done) begin
            pend_d      = w_in_frame;
            pend_full_d = 1'b1;
         end else begin
            w_drop = 1'b1;
         end
      end

      overflow_d = (overflow_q && !ovf_clr) || w_drop;

      if (w_accept) begin
         run_pwr_d = w_max_pwr;
         run_idx_d = w_max_idx;
      end
      if (w_done) begin
         peak_valid_d = 1'b1;
         peak_idx_d   = w_max_idx;
         peak_power_d = w_max_pwr;
         frame_cnt_d  = frame_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         stream_q     <= '0;
         pend_q       <= '0;
         pend_full_q  <= 1'b0;
         out_valid_q  <= 1'b0;
         out_idx_q    <= '0;
         out_real_q   <= '0;
         out_imag_q   <= '0;
         out_power_q  <= '0;
         out_last_q   <= 1'b0;
         run_pwr_q    <= '0;
         run_idx_q    <= '0;
         peak_valid_q <= 1'b0;
         peak_idx_q   <= '0;
         peak_power_q <= '0;
         overflow_q   <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         stream_q     <= stream_d;
         pend_q       <= pend_d;
         pend_full_q  <= pend_full_d;
         out_valid_q  <= out_valid_d;
         out_idx_q    <= out_idx_d;
         out_real_q   <= out_real_d;
         out_imag_q   <= out_imag_d;
         out_power_q  <= out_power_d;
         out_last_q   <= out_last_d;
         run_pwr_q    <= run_pwr_d;
         run_idx_q    <= run_idx_d;
         peak_valid_q <= peak_valid_d;
         peak_idx_q   <= peak_idx_d;
         peak_power_q <= peak_power_d;
         overflow_q   <= overflow_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_idx    = out_idx_q;
   assign out_real   = out_real_q;
   assign out_imag   = out_imag_q;
   assign out_power  = out_power_q;
   assign out_last   = out_last_q;
   assign peak_valid = peak_valid_q;
   assign peak_idx   = peak_idx_q;
   assign peak_power = peak_power_q;
   assign overflow   = overflow_q;
   assign frame_cnt  = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_bin_streamer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fft_bin_streamer: directed and random frames against a frame-level model.
//                                                                      Rev 1.0
// ----------------------------------------------------------------------------
module tb_fft_bin_streamer;

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready, ovf_clr;
   logic [15:0] re_in [8];
   logic [15:0] im_in [8];
   logic        out_valid, out_last, peak_valid, overflow;
   logic [2:0]  out_idx, peak_idx;
   logic [15:0] out_real, out_imag;
   logic [31:0] out_power, peak_power;
   logic [7:0]  frame_cnt;

   always #5 clk = ~clk;

   fft_bin_streamer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .real_in1(re_in[0]), .real_in2(re_in[1]), .real_in3(re_in[2]), .real_in4(re_in[3]),
      .real_in5(re_in[4]), .real_in6(re_in[5]), .real_in7(re_in[6]), .real_in8(re_in[7]),
      .imag_in1(im_in[0]), .imag_in2(im_in[1]), .imag_in3(im_in[2]), .imag_in4(im_in[3]),
      .imag_in5(im_in[4]), .imag_in6(im_in[5]), .imag_in7(im_in[6]), .imag_in8(im_in[7]),
      .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
      .out_real(out_real), .out_imag(out_imag), .out_power(out_power), .out_last(out_last),
      .peak_valid(peak_valid), .peak_idx(peak_idx), .peak_power(peak_power),
      .overflow(overflow), .ovf_clr(ovf_clr), .frame_cnt(frame_cnt)
   );

   typedef struct {
      logic [2:0]  idx;
      logic [15:0] re;
      logic [15:0] im;
      logic [31:0] pwr;
      bit          last;
   } beat_t;

   typedef struct {
      logic [2:0]  idx;
      logic [31:0] pwr;
   } peak_t;

   beat_t       exp_q[$];
   peak_t       pk_q[$];
   bit          just_loaded;
   bit          exp_ovf;
   logic [7:0]  exp_fcnt;
   logic [7:0]  fc0;
   int          checks;
   int          errors;

   function automatic logic [31:0] pw(input logic [15:0] r, input logic [15:0] i);
      longint a;
      longint b;
      a = longint'($signed(r));
      b = longint'($signed(i));
      return 32'(a * a + b * b);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Queue the eight expected beats of the frame on the inputs plus its peak.
   task automatic push_frame();
      beat_t b;
      peak_t pk;
      pk.idx = 3'd0;
      pk.pwr = 32'd0;
      for (int k = 0; k < 8; k++) begin
         b.idx  = 3'(k);
         b.re   = re_in[k];
         b.im   = im_in[k];
         b.pwr  = pw(re_in[k], im_in[k]);
         b.last = (k == 7);
         exp_q.push_back(b);
         if (b.pwr > pk.pwr) begin
            pk.pwr = b.pwr;
            pk.idx = 3'(k);
         end
      end
      pk_q.push_back(pk);
   endtask

   task automatic tick(input bit iv, input bit rdy, input bit clr);
      bit          hs, stall, drop, pk_due, just_next;
      beat_t       b;
      peak_t       pk;
      int          held;
      logic [2:0]  s_idx;
      logic [15:0] s_re, s_im;
      logic [31:0] s_pwr;
      logic        s_last;
      in_valid  = iv;
      out_ready = rdy;
      ovf_clr   = clr;
      pk_due    = 1'b0;
      just_next = 1'b0;
      drop      = 1'b0;
      pk.idx    = 3'd0;
      pk.pwr    = 32'd0;
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0 && !just_loaded));
      hs = out_valid && rdy;
      if (hs && exp_q.size() > 0) begin
         b = exp_q.pop_front();
         chk("beat_idx",   32'(out_idx),   32'(b.idx));
         chk("beat_real",  32'(out_real),  32'(b.re));
         chk("beat_imag",  32'(out_imag),  32'(b.im));
         chk("beat_power", out_power,      b.pwr);
         chk("beat_last",  32'(out_last),  32'(b.last));
         if (b.last) begin
            pk       = pk_q.pop_front();
            pk_due   = 1'b1;
            exp_fcnt = exp_fcnt + 8'd1;
         end
      end
      stall  = out_valid && !rdy;
      s_idx  = out_idx;
      s_re   = out_real;
      s_im   = out_imag;
      s_pwr  = out_power;
      s_last = out_last;
      if (iv) begin
         held = (exp_q.size() + 7) / 8;
         if (held < 2) begin
            just_next = (exp_q.size() == 0);
            push_frame();
         end else begin
            drop = 1'b1;
         end
      end
      exp_ovf = (exp_ovf && !clr) || drop;
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      ovf_clr     = 1'b0;
      just_loaded = just_next;
      chk("peak_valid", 32'(peak_valid), 32'(pk_due));
      if (pk_due) begin
         chk("peak_idx",   32'(peak_idx), 32'(pk.idx));
         chk("peak_power", peak_power,    pk.pwr);
      end
      chk("frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
      chk("overflow",  32'(overflow),  32'(exp_ovf));
      if (stall) begin
         chk("hold_idx",   32'(out_idx),  32'(s_idx));
         chk("hold_real",  32'(out_real), 32'(s_re));
         chk("hold_imag",  32'(out_imag), 32'(s_im));
         chk("hold_power", out_power,     s_pwr);
         chk("hold_last",  32'(out_last), 32'(s_last));
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() > 0 || just_loaded) && n < 200) begin
         tick(1'b0, 1'b1, 1'b0);
         n++;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      tick(1'b0, 1'b1, 1'b0);
   endtask

   task automatic rand_frame();
      for (int k = 0; k < 8; k++) begin
         re_in[k] = ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
         im_in[k] = ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_out_valid"},  32'(out_valid),  32'd0);
      chk({tag, "_out_idx"},    32'(out_idx),    32'd0);
      chk({tag, "_out_real"},   32'(out_real),   32'd0);
      chk({tag, "_out_imag"},   32'(out_imag),   32'd0);
      chk({tag, "_out_power"},  out_power,       32'd0);
      chk({tag, "_out_last"},   32'(out_last),   32'd0);
      chk({tag, "_peak_valid"}, 32'(peak_valid), 32'd0);
      chk({tag, "_peak_idx"},   32'(peak_idx),   32'd0);
      chk({tag, "_peak_power"}, peak_power,      32'd0);
      chk({tag, "_overflow"},   32'(overflow),   32'd0);
      chk({tag, "_frame_cnt"},  32'(frame_cnt),  32'd0);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      ovf_clr     = 1'b0;
      exp_fcnt    = 8'd0;
      exp_ovf     = 1'b0;
      just_loaded = 1'b0;
      for (int k = 0; k < 8; k++) begin
         re_in[k] = 16'd0;
         im_in[k] = 16'd0;
      end
      #12;
      chk_reset_vals("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single ramp frame with the consumer always ready
      for (int k = 0; k < 8; k++) begin
         re_in[k] = 16'(100 * k);
         im_in[k] = 16'(-50 * k);
      end
      tick(1'b1, 1'b1, 1'b0);
      repeat (10) tick(1'b0, 1'b1, 1'b0);
      chk("ramp_peak_idx",   32'(peak_idx),  32'd7);
      chk("ramp_peak_power", peak_power,     32'd612500);
      chk("ramp_frame_cnt",  32'(frame_cnt), 32'd1);

      // Equal powers everywhere: the lowest index must win
      for (int k = 0; k < 8; k++) begin
         re_in[k] = 16'd1000;
         im_in[k] = 16'd0;
      end
      tick(1'b1, 1'b1, 1'b0);
      repeat (10) tick(1'b0, 1'b1, 1'b0);
      chk("tie_peak_idx",   32'(peak_idx), 32'd0);
      chk("tie_peak_power", peak_power,    32'd1000000);

      // Most negative components on bin 3 only
      for (int k = 0; k < 8; k++) begin
         re_in[k] = 16'd0;
         im_in[k] = 16'd0;
      end
      re_in[3] = 16'h8000;
      im_in[3] = 16'h8000;
      tick(1'b1, 1'b1, 1'b0);
      repeat (10) tick(1'b0, 1'b1, 1'b0);
      chk("ext_peak_idx",   32'(peak_idx), 32'd3);
      chk("ext_peak_power", peak_power,    32'h8000_0000);

      // Alternating ready with a second frame waiting in PEND
      rand_frame();
      tick(1'b1, 1'b1, 1'b0);
      rand_frame();
      tick(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) tick(1'b0, (i % 2) == 0, 1'b0);
      drain();

      // New frame on the very edge the last beat leaves with PEND full
      rand_frame();
      tick(1'b1, 1'b1, 1'b0);
      rand_frame();
      tick(1'b1, 1'b1, 1'b0);
      repeat (7) tick(1'b0, 1'b1, 1'b0);
      rand_frame();
      tick(1'b1, 1'b1, 1'b0);
      drain();
      chk("sameedge_no_ovf", 32'(overflow), 32'd0);

      // Third back-to-back frame while stalled is dropped
      fc0 = exp_fcnt;
      for (int f = 0; f < 3; f++) begin
         rand_frame();
         tick(1'b1, 1'b0, 1'b0);
      end
      repeat (20) tick(1'b0, 1'b1, 1'b0);
      chk("ovf_set",       32'(overflow),  32'd1);
      chk("ovf_frame_cnt", 32'(frame_cnt), 32'(fc0 + 8'd2));
      tick(1'b0, 1'b1, 1'b1);
      chk("ovf_cleared", 32'(overflow), 32'd0);

      // Drop coincident with clear keeps the flag set
      rand_frame();
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b1);
      chk("ovf_drop_wins", 32'(overflow), 32'd1);
      drain();
      tick(1'b0, 1'b1, 1'b1);

      // Random traffic, ready and clears
      for (int i = 0; i < 400; i++) begin
         bit iv;
         iv = ($urandom_range(0, 3) == 0);
         if (iv) rand_frame();
         tick(iv, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      end
      drain();

      // Reset after the bin 4 beat
      rand_frame();
      tick(1'b1, 1'b1, 1'b0);
      repeat (6) tick(1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      chk_reset_vals("midrst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      pk_q.delete();
      exp_fcnt    = 8'd0;
      exp_ovf     = 1'b0;
      just_loaded = 1'b0;
      repeat (5) tick(1'b0, 1'b1, 1'b0);
      rand_frame();
      tick(1'b1, 1'b1, 1'b0);
      repeat (10) tick(1'b0, 1'b1, 1'b0);
      chk("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
